// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with an internal byte FIFO.
//
// Bytes arrive from the peripheral bus over a write strobe. They are queued
// in a circular FIFO and sent LSB-first on uart_txd. Bit timing comes from a
// free-running x16 oversampling enable, so one bit lasts 16*divisor clocks.
//
// Handshake: a byte is taken on any rising clk edge where tx_wr && tx_ready.
// tx_ready is high whenever the FIFO is not full and does not depend on
// tx_wr. A write while tx_ready is low is dropped and changes nothing.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   tx_data     in   byte to queue
//   tx_wr       in   write strobe
//   tx_ready    out  FIFO not full
//   tx_busy     out  frame on the line or FIFO non-empty
//   fifo_level  out  current FIFO occupancy
//   uart_txd    out  serial line, idles high, driven from a flop
//   dbg_state_o out  transmit FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Parameters: freq_hz/baud must be at least 16, and fifo_depth must be a
// power of two no smaller than 2.
module uart_tx #(
  parameter int unsigned freq_hz    = 50_000_000,
  parameter int unsigned baud       = 115200,
  parameter int unsigned fifo_depth = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [$clog2(fifo_depth):0] fifo_level,
  output logic                        uart_txd,
  output logic [1:0]                  dbg_state_o
);

  localparam int unsigned divisor = freq_hz / baud / 16;
  localparam int unsigned AW      = $clog2(fifo_depth);
  localparam int unsigned LW      = AW + 1;

  localparam logic [15:0]   DIV_RELOAD = 16'(divisor - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(fifo_depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // x16 enable generator. Free-running: frames do not resynchronise it,
  // which is why the first start bit can lag an accept by up to divisor
  // clocks.
  // ---------------------------------------------------------------------
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        enable16;

  assign enable16 = (div_cnt_q == 16'd0);

  always_comb begin
    div_cnt_d = enable16 ? DIV_RELOAD : (div_cnt_q - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= DIV_RELOAD;
    else       div_cnt_q <= div_cnt_d;
  end

  // ---------------------------------------------------------------------
  // FIFO. Pointers wrap naturally because the depth is a power of two.
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [fifo_depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          accept;
  logic          pop;
  logic          fifo_nonempty;

  assign tx_ready      = (level_q != LEVEL_FULL);
  assign accept        = tx_wr && tx_ready;
  assign fifo_nonempty = (level_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      // Simultaneous accept and pop leave the level unchanged.
      if (accept && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !accept) level_q <= level_q - LW'(1);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem_q[wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       bit_end;

  // Last enable16 tick of the current bit period.
  assign bit_end = enable16 && (tick_q == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable16 && fifo_nonempty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = fifo_nonempty ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    pop     = 1'b0;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    // The 4-bit tick counter wraps 15 -> 0 on its own at each bit boundary.
    if ((state_q != IDLE) && enable16) tick_d = tick_q + 4'd1;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (enable16 && fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          tick_d  = 4'd0;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d = shift_q[0];
          bit_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q != 3'd7) begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end else begin
            txd_d = 1'b1;
          end
        end
      end
      STOP: begin
        // Back-to-back: the next start bit begins on the stop-end edge.
        if (bit_end && fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase
  end

  assign uart_txd    = txd_q;
  assign tx_busy     = (state_q != IDLE) || fifo_nonempty;
  assign fifo_level  = level_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with a 16-clock bit and a
// 4-entry FIFO. A line monitor decodes frames at bit centres and compares
// each byte against the head of the expected queue.
module tb_uart_tx;

  localparam int unsigned FREQ  = 1_600_000;
  localparam int unsigned BAUD  = 100_000;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_wr = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic       uart_txd;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];

  uart_tx #(
    .freq_hz    (FREQ),
    .baud       (BAUD),
    .fifo_depth (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .uart_txd    (uart_txd),
    .dbg_state_o (dbg_state)
  );

  // Clock and edge counter: right after edge k (plus #1), cyc == k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after edge number target (no-op if already there).
  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte for exactly one edge; push it if the bench expects it sent.
  task automatic write_byte(input logic [7:0] d, input bit expect_sent);
    tx_data = d;
    tx_wr   = 1'b1;
    if (expect_sent) exp_q.push_back(d);
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < 4000), 32'd1);
    check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: bit centres are 8 clocks into each 16-clock bit.
  int         mon_cnt = 0;
  logic       mon_active = 1'b0;
  logic [7:0] mon_byte = 8'd0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 8) begin
        check("start_bit", 32'(uart_txd), 32'd0);
      end else if (mon_cnt >= 24 && mon_cnt <= 136 && ((mon_cnt - 8) % 16) == 0) begin
        mon_byte[(mon_cnt - 24) / 16] = uart_txd;
      end else if (mon_cnt == 152) begin
        check("stop_bit", 32'(uart_txd), 32'd1);
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("frame_byte", 32'(mon_byte), 32'(mon_exp));
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    int base;

    // 1. Reset idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check("idle_txd", 32'(uart_txd), 32'd1);
      check("idle_ready", 32'(tx_ready), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
      check("idle_level", 32'(fifo_level), 32'd0);
    end

    // 2. Single byte 0xA5
    write_byte(8'hA5, 1'b1);
    check("single_level_after_accept", 32'(fifo_level), 32'd1);
    check("single_txd_before_fall", 32'(uart_txd), 32'd1);
    check("single_busy_after_accept", 32'(tx_busy), 32'd1);
    base = cyc + 1;
    wait_until(base);
    check("single_fall", 32'(uart_txd), 32'd0);
    check("single_level_after_pop", 32'(fifo_level), 32'd0);
    check("single_state_start", 32'(dbg_state), 32'd1);
    wait_until(base + 15);
    check("single_start_last", 32'(uart_txd), 32'd0);
    wait_until(base + 16);
    check("single_d0_first", 32'(uart_txd), 32'd1);
    wait_until(base + 159);
    check("single_busy_159", 32'(tx_busy), 32'd1);
    check("single_stop_159", 32'(uart_txd), 32'd1);
    wait_until(base + 160);
    check("single_busy_160", 32'(tx_busy), 32'd0);
    check("single_txd_160", 32'(uart_txd), 32'd1);
    wait_idle("single");
    repeat (10) @(posedge clk);
    #1;

    // 3. Back-to-back 0x00, 0xFF, 0x55
    write_byte(8'h00, 1'b1);
    base = cyc + 1;
    write_byte(8'hFF, 1'b1);
    write_byte(8'h55, 1'b1);
    wait_until(base + 143);
    check("b2b_f0_d7", 32'(uart_txd), 32'd0);
    for (int f = 0; f < 3; f++) begin
      wait_until(base + 160 * f + 144);
      check("b2b_stop_begin", 32'(uart_txd), 32'd1);
      wait_until(base + 160 * f + 159);
      check("b2b_stop_end", 32'(uart_txd), 32'd1);
      if (f < 2) begin
        wait_until(base + 160 * f + 160);
        check("b2b_next_start", 32'(uart_txd), 32'd0);
      end
    end
    check("b2b_busy_479", 32'(tx_busy), 32'd1);
    wait_until(base + 480);
    check("b2b_busy_480", 32'(tx_busy), 32'd0);
    check("b2b_txd_480", 32'(uart_txd), 32'd1);
    wait_idle("b2b");
    repeat (10) @(posedge clk);
    #1;

    // 4. Full FIFO: 0x01..0x05 accepted, 0x06 dropped
    write_byte(8'h01, 1'b1);
    base = cyc + 1;
    check("full_level_1", 32'(fifo_level), 32'd1);
    write_byte(8'h02, 1'b1);
    check("full_level_2", 32'(fifo_level), 32'd1);
    write_byte(8'h03, 1'b1);
    check("full_level_3", 32'(fifo_level), 32'd2);
    write_byte(8'h04, 1'b1);
    check("full_level_4", 32'(fifo_level), 32'd3);
    check("full_ready_4", 32'(tx_ready), 32'd1);
    write_byte(8'h05, 1'b1);
    check("full_level_5", 32'(fifo_level), 32'd4);
    check("full_ready_5", 32'(tx_ready), 32'd0);
    write_byte(8'h06, 1'b0);
    check("full_level_drop", 32'(fifo_level), 32'd4);
    check("full_ready_drop", 32'(tx_ready), 32'd0);
    wait_until(base + 159);
    check("full_ready_before_pop", 32'(tx_ready), 32'd0);
    check("full_level_before_pop", 32'(fifo_level), 32'd4);
    wait_until(base + 160);
    check("full_ready_after_pop", 32'(tx_ready), 32'd1);
    check("full_level_after_pop", 32'(fifo_level), 32'd3);
    wait_idle("full");
    repeat (10) @(posedge clk);
    #1;

    // 5. Simultaneous accept and pop at level 2
    write_byte(8'h12, 1'b1);
    base = cyc + 1;
    write_byte(8'h34, 1'b1);
    write_byte(8'h56, 1'b1);
    check("sim_level_setup", 32'(fifo_level), 32'd2);
    wait_until(base + 159);
    check("sim_level_before", 32'(fifo_level), 32'd2);
    write_byte(8'h78, 1'b1);
    check("sim_level_after", 32'(fifo_level), 32'd2);
    check("sim_next_start", 32'(uart_txd), 32'd0);
    check("sim_ready", 32'(tx_ready), 32'd1);
    wait_idle("sim");
    repeat (10) @(posedge clk);
    #1;

    // 6. Reset during d3 with two bytes queued
    write_byte(8'h3C, 1'b1);
    base = cyc + 1;
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    wait_until(base + 70);
    check("midrst_level_before", 32'(fifo_level), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_txd", 32'(uart_txd), 32'd1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      check("postrst_txd", 32'(uart_txd), 32'd1);
      check("postrst_busy", 32'(tx_busy), 32'd0);
    end
    write_byte(8'h81, 1'b1);
    wait_idle("postrst");
    repeat (5) @(posedge clk);
    #1;

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
